// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_arbiter
// Brief    : Synchronises N asynchronous level inputs, latches enabled edge
//            events per channel and presents them one at a time through a
//            round-robin valid/ready port with per-channel overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
    parameter int N        = 4,
    parameter int SYNC_STG = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in,
    input  logic [N-1:0]         rise_en,
    input  logic [N-1:0]         fall_en,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [$clog2(N)-1:0] ev_chn,
    output logic                 ev_rising,
    output logic [N-1:0]         pending,
    output logic [N-1:0]         ovf,
    input  logic [N-1:0]         ovf_clr
);

    localparam int C_IW  = $clog2(N);
    localparam int C_ARM = SYNC_STG + 1;
    localparam int C_AW  = $clog2(C_ARM + 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronisers and history
    // ------------------------------------------------------------------------
    logic [N-1:0] r_sync [SYNC_STG];
    logic [N-1:0] r_prv;
    logic [N-1:0] w_cur;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STG; s++) begin
                r_sync[s] <= '0;
            end
            r_prv <= '0;
        end else begin
            r_sync[0] <= in;
            for (int s = 1; s < SYNC_STG; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prv <= w_cur;
        end
    end

    assign w_cur = r_sync[SYNC_STG-1];

    // Detection stays off until the chain and history hold real samples, so a
    // level that was already high at reset never looks like an edge.
    logic [C_AW-1:0] r_arm;
    logic            w_armed;

    assign w_armed = (r_arm == C_AW'(C_ARM));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_arm <= '0;
        end else if (!w_armed) begin
            r_arm <= r_arm + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Edge detect and per-channel event latches
    // ------------------------------------------------------------------------
    logic [N-1:0] w_rise;
    logic [N-1:0] w_fall;
    logic [N-1:0] w_det;
    logic [N-1:0] w_take;
    logic [N-1:0] w_drop;
    logic [N-1:0] w_gnt;
    logic [N-1:0] r_pend;
    logic [N-1:0] r_dir;
    logic [N-1:0] r_ovf;

    assign w_rise = w_cur & ~r_prv & rise_en & {N{w_armed}};
    assign w_fall = ~w_cur & r_prv & fall_en & {N{w_armed}};
    assign w_det  = w_rise | w_fall;

    // A channel being granted this cycle frees its slot for a same-cycle detect.
    assign w_take = w_det & (~r_pend | w_gnt);
    assign w_drop = w_det & r_pend & ~w_gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_dir  <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_gnt) | w_take;
            r_dir  <= (r_dir & ~w_take) | (w_rise & w_take);
            r_ovf  <= (r_ovf & ~ovf_clr) | w_drop;
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic [C_IW-1:0] r_ptr;
    logic            r_valid;
    logic [C_IW-1:0] r_chn;
    logic            r_rising;
    logic            w_load;
    logic            w_hit;
    logic [C_IW-1:0] w_gnt_idx;

    function automatic logic [C_IW-1:0] f_wrap(input int v);
        return C_IW'(v % N);
    endfunction

    always_comb begin
        w_gnt_idx = r_ptr;
        w_hit     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!w_hit && r_pend[f_wrap(int'(r_ptr) + k)]) begin
                w_gnt_idx = f_wrap(int'(r_ptr) + k);
                w_hit     = 1'b1;
            end
        end
    end

    assign w_load = (r_state == S_IDLE) || ev_ready;
    assign w_gnt  = (w_load && w_hit) ? ({{(N-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_chn    <= '0;
            r_rising <= 1'b0;
            r_ptr    <= C_IW'(N - 1);
        end else begin
            case (r_state)
                S_IDLE, S_PRESENT: begin
                    if (w_load) begin
                        if (w_hit) begin
                            r_state  <= S_PRESENT;
                            r_valid  <= 1'b1;
                            r_chn    <= w_gnt_idx;
                            r_rising <= r_dir[w_gnt_idx];
                            r_ptr    <= w_gnt_idx;
                        end else begin
                            r_state  <= S_IDLE;
                            r_valid  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ev_valid  = r_valid;
    assign ev_chn    = r_chn;
    assign ev_rising = r_rising;
    assign pending   = r_pend;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
